laser_pulse_gen: RTL and testbench

LASER_PULSE_GEN -- requirements
Module: laser_pulse_gen

---
 rtl/laser_pulse_gen.sv | 210 +++++++++++++++++++++
 tb/tb_laser_pulse_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_pulse_gen.sv
// Trigger-driven laser pulse sequencer: delay, pulse, then round-robin advance over the channel mask.
// Defining LASER_PULSE_CNT_EN adds the 32-bit completed-pulse counter output pulse_cnt.
module laser_pulse_gen #(
    parameter int  CH_NUM = 4,
    parameter int  CNT_W  = 16,
    localparam int SEL_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              laser_enable,
    input  logic              send_en,
    input  logic              auto_mode,
    input  logic [CNT_W-1:0]  cfg_delay,
    input  logic [CNT_W-1:0]  cfg_width,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CH_NUM-1:0] ch_mask,
    output logic [CH_NUM-1:0] send_data,
    output logic              busy,
    output logic [SEL_W-1:0]  ch_sel,
    output logic              trig_drop
`ifdef LASER_PULSE_CNT_EN
    ,
    output logic [31:0]       pulse_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CH_NUM-1:0] CH_ZERO  = {CH_NUM{1'b0}};

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    dly_sh_r;
    logic [CNT_W-1:0]    wid_sh_r;
    logic [CNT_W-1:0]    per_cnt_r;
    logic [SEL_W-1:0]    ch_sel_r;
    logic [CH_NUM-1:0]   send_data_r;
    logic                busy_r;
    logic                trig_drop_r;
`ifdef LASER_PULSE_CNT_EN
    logic [31:0]         pulse_cnt_r;
`endif

    logic                tick_s;
    logic                trig_s;
    logic                accept_s;
    logic [SEL_W-1:0]    fire_ch_s;
    logic [SEL_W-1:0]    adv_ch_s;

    // First set mask bit at or above start, else the lowest set bit (wrap); fallback when mask is empty.
    function automatic logic [SEL_W-1:0] next_set(input logic [CH_NUM-1:0] mask,
                                                  input int start,
                                                  input logic [SEL_W-1:0] fallback);
        logic [SEL_W-1:0] low_idx;
        logic [SEL_W-1:0] above_idx;
        logic             low_ok;
        logic             above_ok;
        low_idx   = fallback;
        above_idx = fallback;
        low_ok    = 1'b0;
        above_ok  = 1'b0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (mask[k] && !low_ok) begin
                low_idx = SEL_W'(k);
                low_ok  = 1'b1;
            end
            if (mask[k] && !above_ok && (k >= start)) begin
                above_idx = SEL_W'(k);
                above_ok  = 1'b1;
            end
        end
        if (above_ok) begin
            return above_idx;
        end else if (low_ok) begin
            return low_idx;
        end else begin
            return fallback;
        end
    endfunction

    function automatic logic [CH_NUM-1:0] one_hot(input logic [SEL_W-1:0] idx);
        logic [CH_NUM-1:0] v;
        for (int k = 0; k < CH_NUM; k++) begin
            v[k] = (SEL_W'(k) == idx);
        end
        return v;
    endfunction

    // Trigger source selection and acceptance qualification.
    always_comb begin
        tick_s = 1'b0;
        if (auto_mode && laser_enable && (cfg_period != CNT_ZERO)) begin
            tick_s = (per_cnt_r >= (cfg_period - CNT_ONE));
        end else begin
            tick_s = 1'b0;
        end
        trig_s    = auto_mode ? tick_s : send_en;
        accept_s  = trig_s && (state_r == IDLE) && laser_enable && (ch_mask != CH_ZERO);
        fire_ch_s = next_set(ch_mask, int'(ch_sel_r), ch_sel_r);
        adv_ch_s  = next_set(ch_mask, int'(ch_sel_r) + 1, ch_sel_r);
    end

    // Auto-mode period counter; held at zero whenever auto firing is not armed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            per_cnt_r <= CNT_ZERO;
        end else if (auto_mode && laser_enable && (cfg_period != CNT_ZERO)) begin
            if (tick_s) begin
                per_cnt_r <= CNT_ZERO;
            end else begin
                per_cnt_r <= per_cnt_r + CNT_ONE;
            end
        end else begin
            per_cnt_r <= CNT_ZERO;
        end
    end

    // Pulse FSM with registered outputs; dropping laser_enable aborts without advancing ch_sel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            dly_sh_r    <= CNT_ZERO;
            wid_sh_r    <= CNT_ZERO;
            ch_sel_r    <= {SEL_W{1'b0}};
            send_data_r <= CH_ZERO;
            busy_r      <= 1'b0;
            trig_drop_r <= 1'b0;
`ifdef LASER_PULSE_CNT_EN
            pulse_cnt_r <= 32'd0;
`endif
        end else begin
            trig_drop_r <= trig_s && !accept_s;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        dly_sh_r <= cfg_delay;
                        wid_sh_r <= (cfg_width == CNT_ZERO) ? CNT_ONE : cfg_width;
                        cnt_r    <= CNT_ZERO;
                        ch_sel_r <= fire_ch_s;
                        busy_r   <= 1'b1;
                        if (cfg_delay == CNT_ZERO) begin
                            state_r     <= PULSE;
                            send_data_r <= one_hot(fire_ch_s);
                        end else begin
                            state_r <= DELAY;
                        end
                    end else begin
                        send_data_r <= CH_ZERO;
                        busy_r      <= 1'b0;
                    end
                end
                DELAY: begin
                    if (!laser_enable) begin
                        state_r     <= IDLE;
                        cnt_r       <= CNT_ZERO;
                        busy_r      <= 1'b0;
                        send_data_r <= CH_ZERO;
                    end else if (cnt_r == (dly_sh_r - CNT_ONE)) begin
                        state_r     <= PULSE;
                        cnt_r       <= CNT_ZERO;
                        send_data_r <= one_hot(ch_sel_r);
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                PULSE: begin
                    if (!laser_enable) begin
                        state_r     <= IDLE;
                        cnt_r       <= CNT_ZERO;
                        busy_r      <= 1'b0;
                        send_data_r <= CH_ZERO;
                    end else if (cnt_r == (wid_sh_r - CNT_ONE)) begin
                        state_r     <= IDLE;
                        cnt_r       <= CNT_ZERO;
                        busy_r      <= 1'b0;
                        send_data_r <= CH_ZERO;
                        ch_sel_r    <= adv_ch_s;
`ifdef LASER_PULSE_CNT_EN
                        pulse_cnt_r <= pulse_cnt_r + 32'd1;
`endif
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= CNT_ZERO;
                    busy_r      <= 1'b0;
                    send_data_r <= CH_ZERO;
                end
            endcase
        end
    end

    assign send_data = send_data_r;
    assign busy      = busy_r;
    assign ch_sel    = ch_sel_r;
    assign trig_drop = trig_drop_r;
`ifdef LASER_PULSE_CNT_EN
    assign pulse_cnt = pulse_cnt_r;
`endif

endmodule

// File: tb/tb_laser_pulse_gen.sv
// Bench for laser_pulse_gen: directed scenarios plus random stimulus against a timestamp-based model.
// Build with LASER_PULSE_CNT_EN defined to also check pulse_cnt.
module tb_laser_pulse_gen;
    localparam int CH = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          laser_enable;
    logic          send_en;
    logic          auto_mode;
    logic [CW-1:0] cfg_delay;
    logic [CW-1:0] cfg_width;
    logic [CW-1:0] cfg_period;
    logic [CH-1:0] ch_mask;
    logic [CH-1:0] send_data;
    logic          busy;
    logic [1:0]    ch_sel;
    logic          trig_drop;
`ifdef LASER_PULSE_CNT_EN
    logic [31:0]   pulse_cnt;
`endif

    laser_pulse_gen #(.CH_NUM(CH), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .laser_enable (laser_enable),
        .send_en      (send_en),
        .auto_mode    (auto_mode),
        .cfg_delay    (cfg_delay),
        .cfg_width    (cfg_width),
        .cfg_period   (cfg_period),
        .ch_mask      (ch_mask),
        .send_data    (send_data),
        .busy         (busy),
        .ch_sel       (ch_sel),
        .trig_drop    (trig_drop)
`ifdef LASER_PULSE_CNT_EN
        ,
        .pulse_cnt    (pulse_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: a pulse is a time window [m_start, m_end] fixed at acceptance time.
    bit          m_fly   = 1'b0;
    int          m_start = 0;
    int          m_end   = 0;
    int          m_ch    = 0;
    int          m_sel   = 0;
    bit          m_drop  = 1'b0;
    int          m_phase = 0;
    int unsigned m_pcnt  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int nxt_ch(input int from, input logic [CH-1:0] m, input int first_k);
        for (int k = first_k; k <= CH; k++) begin
            int idx;
            idx = (from + k) % CH;
            if (m[idx]) return idx;
        end
        return from;
    endfunction

    task automatic model_step();
        bit tick;
        bit trig;
        if (!rst_n) begin
            m_fly   = 1'b0;
            m_sel   = 0;
            m_drop  = 1'b0;
            m_phase = 0;
            m_pcnt  = 0;
        end else begin
            tick = auto_mode && laser_enable && (cfg_period != '0) &&
                   (m_phase == int'(cfg_period) - 1);
            trig = auto_mode ? tick : send_en;
            if (m_fly) begin
                m_drop = trig;
                if (!laser_enable) begin
                    m_fly = 1'b0;
                end else if (cyc == m_end) begin
                    m_fly = 1'b0;
                    m_sel = nxt_ch(m_ch, ch_mask, 1);
                    m_pcnt++;
                end
            end else if (trig && laser_enable && (ch_mask != '0)) begin
                m_ch    = nxt_ch(m_sel, ch_mask, 0);
                m_sel   = m_ch;
                m_start = cyc + 1 + int'(cfg_delay);
                m_end   = m_start - 1 + ((cfg_width == '0) ? 1 : int'(cfg_width));
                m_fly   = 1'b1;
                m_drop  = 1'b0;
            end else begin
                m_drop = trig;
            end
            if (auto_mode && laser_enable && (cfg_period != '0)) begin
                m_phase = tick ? 0 : m_phase + 1;
            end else begin
                m_phase = 0;
            end
        end
    endtask

    task automatic check_outputs();
        check_val("busy", 32'(busy), 32'(m_fly));
        check_val("send_data", 32'(send_data), (m_fly && cyc >= m_start) ? (32'd1 << m_ch) : 32'd0);
        check_val("ch_sel", 32'(ch_sel), 32'(m_sel));
        check_val("trig_drop", 32'(trig_drop), 32'(m_drop));
        check_val("onehot", 32'($countones(send_data) <= 1), 32'd1);
`ifdef LASER_PULSE_CNT_EN
        check_val("pulse_cnt", pulse_cnt, 32'(m_pcnt));
`endif
    endtask

    task automatic tick_clk();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick_clk();
        rst_n = 1'b1;
        tick_clk();
    endtask

    logic [CH-1:0] r034_seq [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};

    initial begin
        rst_n        = 1'b0;
        laser_enable = 1'b1;
        send_en      = 1'b0;
        auto_mode    = 1'b0;
        cfg_delay    = 16'd0;
        cfg_width    = 16'd0;
        cfg_period   = 16'd0;
        ch_mask      = 4'b1111;
        repeat (2) tick_clk();
        check_val("rst_send_data", 32'(send_data), 32'd0);
        check_val("rst_ch_sel", 32'(ch_sel), 32'd0);
        rst_n = 1'b1;
        repeat (3) tick_clk();

        // Delay 2, width 3 on channel 0, then ch_sel moves to 1
        cfg_delay = 16'd2;
        cfg_width = 16'd3;
        for (int i = 0; i < 8; i++) begin
            send_en = (i == 0);
            tick_clk();
            if (i >= 2 && i <= 4) check_val("r033_high", 32'(send_data), 32'h1);
            if (i == 5) begin
                check_val("r033_low", 32'(send_data), 32'h0);
                check_val("r033_sel", 32'(ch_sel), 32'd1);
            end
        end

        // Sparse mask 1010 from ch_sel 0 fires 1,3,1,3
        do_reset();
        ch_mask   = 4'b1010;
        cfg_delay = 16'd0;
        cfg_width = 16'd0;
        for (int i = 0; i < 20; i++) begin
            send_en = (i % 5 == 0);
            tick_clk();
            if (i % 5 == 0) check_val("r034_order", 32'(send_data), 32'(r034_seq[i / 5]));
        end

        // Re-trigger during PULSE is dropped
        ch_mask   = 4'b1111;
        cfg_delay = 16'd1;
        cfg_width = 16'd4;
        for (int i = 0; i < 10; i++) begin
            send_en = (i == 0) || (i == 3);
            tick_clk();
            if (i == 3) check_val("r035_drop", 32'(trig_drop), 32'd1);
        end

        // Auto mode every 8 cycles, then period 0 stops firing
        send_en   = 1'b0;
        auto_mode = 1'b1;
        cfg_delay = 16'd0;
        cfg_width = 16'd2;
        cfg_period = 16'd8;
        repeat (40) tick_clk();
        cfg_period = 16'd0;
        repeat (20) tick_clk();
        auto_mode = 1'b0;

        // laser_enable dropped in the second pulse cycle
        cfg_width = 16'd5;
        for (int i = 0; i < 8; i++) begin
            send_en      = (i == 0);
            laser_enable = (i != 2);
            tick_clk();
            if (i == 2) check_val("r037_abort", 32'(send_data), 32'd0);
        end

        // Reset during DELAY leaves nothing pending
        cfg_delay = 16'd5;
        cfg_width = 16'd2;
        for (int i = 0; i < 12; i++) begin
            send_en = (i == 0);
            rst_n   = (i != 2);
            tick_clk();
        end

        // Random stimulus; cfg_period only changes while auto_mode is forced low
        for (int i = 0; i < 2000; i++) begin
            rst_n        = ($urandom_range(0, 99) != 0);
            laser_enable = ($urandom_range(0, 15) != 0);
            send_en      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) ch_mask = 4'($urandom_range(0, 15));
            cfg_delay = 16'($urandom_range(0, 3));
            cfg_width = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) begin
                auto_mode  = 1'b0;
                cfg_period = 16'($urandom_range(0, 6));
            end else if ($urandom_range(0, 29) == 0) begin
                auto_mode = ~auto_mode;
            end
            tick_clk();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
